ped_request_unit: RTL and testbench



---
 rtl/ped_request_unit_if.sv | 22 ++
 rtl/ped_request_unit.sv | 149 ++++++++++++++
 tb/tb_ped_request_unit.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/ped_request_unit_if.sv
// Pedestrian request bus: raw button and walk indication in, request/status out.
interface ped_request_unit_if #(
  parameter int unsigned CNT_W = 8
);
  logic             btn_raw;
  logic             ped_green;
  logic             ped_req;
  logic             wait_lamp;
  logic             walk_active;
  logic [CNT_W-1:0] served_cnt;
  logic             req_timeout;

  modport master (
    output btn_raw, ped_green,
    input  ped_req, wait_lamp, walk_active, served_cnt, req_timeout
  );

  modport slave (
    input  btn_raw, ped_green,
    output ped_req, wait_lamp, walk_active, served_cnt, req_timeout
  );
endinterface

// File: rtl/ped_request_unit.sv
// Pedestrian front end: button sync/debounce, request/walk/cooldown FSM, served counter.
// Optional request-age timeout flag enabled by defining PED_REQ_TIMEOUT_EN.
module ped_request_unit #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned COOLDOWN_CYCLES = 20,
  parameter int unsigned TIMEOUT_CYCLES  = 64,
  parameter int unsigned CNT_W           = 8
) (
  input  logic              clk,
  input  logic              reset,
  ped_request_unit_if.slave bus
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned CD_W = $clog2(COOLDOWN_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQUEST, WALK, COOLDOWN} state_t;

  state_t          state;
  logic            sync1;
  logic            sync2;
  logic            db;
  logic            db_q;
  logic [DB_W-1:0] db_cnt;
  logic            pending;
  logic [CD_W-1:0] cd_cnt;
  logic            press;

  // Single-cycle pulse on the debounced rising edge; releases are not events.
  assign press = db & ~db_q;

  // Two-flop synchronizer followed by a stability-count debouncer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      db     <= 1'b0;
      db_q   <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync1 <= bus.btn_raw;
      sync2 <= sync1;
      db_q  <= db;
      if (sync2 == db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db     <= ~db;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // Request FSM; outputs are set alongside each transition so they stay registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      pending         <= 1'b0;
      cd_cnt          <= '0;
      bus.ped_req     <= 1'b0;
      bus.wait_lamp   <= 1'b0;
      bus.walk_active <= 1'b0;
      bus.served_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (press) begin
            state         <= REQUEST;
            bus.ped_req   <= 1'b1;
            bus.wait_lamp <= 1'b1;
          end
        end
        REQUEST: begin
          if (bus.ped_green) begin
            state           <= WALK;
            bus.ped_req     <= 1'b0;
            bus.wait_lamp   <= 1'b0;
            bus.walk_active <= 1'b1;
          end
        end
        WALK: begin
          if (press) pending <= 1'b1;
          if (!bus.ped_green) begin
            state           <= COOLDOWN;
            cd_cnt          <= '0;
            bus.walk_active <= 1'b0;
            bus.wait_lamp   <= pending | press;
            if (bus.served_cnt != {CNT_W{1'b1}})
              bus.served_cnt <= bus.served_cnt + CNT_W'(1);
          end
        end
        COOLDOWN: begin
          if (cd_cnt == CD_W'(COOLDOWN_CYCLES - 1)) begin
            // A press landing on the expiry cycle counts as pending.
            if (pending | press) begin
              state         <= REQUEST;
              pending       <= 1'b0;
              bus.ped_req   <= 1'b1;
              bus.wait_lamp <= 1'b1;
            end else begin
              state         <= IDLE;
              bus.wait_lamp <= 1'b0;
            end
          end else begin
            cd_cnt <= cd_cnt + CD_W'(1);
            if (press) begin
              pending       <= 1'b1;
              bus.wait_lamp <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef PED_REQ_TIMEOUT_EN
  localparam int unsigned AGE_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [AGE_W-1:0] age;

  // Request age; the flag is sticky until reset and does not affect the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      age             <= '0;
      bus.req_timeout <= 1'b0;
    end else if (state == REQUEST) begin
      if (age == AGE_W'(TIMEOUT_CYCLES - 1)) begin
        bus.req_timeout <= 1'b1;
      end else begin
        age <= age + AGE_W'(1);
      end
    end else begin
      age <= '0;
    end
  end
`else
  localparam int unsigned AGE_W = $clog2(TIMEOUT_CYCLES + 1);

  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^AGE_W'(TIMEOUT_CYCLES);
  assign bus.req_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_ped_request_unit.sv
// Directed bench for ped_request_unit: latency, bounce, walk cycle, pending, reset, timeout.
module tb_ped_request_unit;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic exp_to;

  ped_request_unit_if #(.CNT_W(8)) bus ();

  ped_request_unit #(
    .DEBOUNCE_CYCLES(4),
    .COOLDOWN_CYCLES(20),
    .TIMEOUT_CYCLES (16),
    .CNT_W          (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold the button until the request appears; release edges are ignored by the DUT.
  task automatic do_press(input string tag);
    bus.btn_raw = 1'b1;
    tick(6);
    check({tag, "_early"}, 32'(bus.ped_req), 32'd0);
    tick(1);
    check({tag, "_req"}, 32'(bus.ped_req), 32'd1);
    bus.btn_raw = 1'b0;
  endtask

  initial begin
    total         = 0;
    bad           = 0;
`ifdef PED_REQ_TIMEOUT_EN
    exp_to        = 1'b1;
`else
    exp_to        = 1'b0;
`endif
    reset         = 1'b1;
    bus.btn_raw   = 1'b0;
    bus.ped_green = 1'b0;

    tick(2);
    check("rst_req",     32'(bus.ped_req),     32'd0);
    check("rst_lamp",    32'(bus.wait_lamp),   32'd0);
    check("rst_walk",    32'(bus.walk_active), 32'd0);
    check("rst_served",  32'(bus.served_cnt),  32'd0);
    check("rst_timeout", 32'(bus.req_timeout), 32'd0);
    reset = 1'b0;

    // Latency: button high for 20 cycles, request on the 7th edge.
    bus.btn_raw = 1'b1;
    tick(6);
    check("lat_early", 32'(bus.ped_req), 32'd0);
    tick(1);
    check("lat_req",    32'(bus.ped_req),    32'd1);
    check("lat_lamp",   32'(bus.wait_lamp),  32'd1);
    check("lat_served", 32'(bus.served_cnt), 32'd0);
    tick(13);
    bus.btn_raw = 1'b0;
    check("lat_hold_req",  32'(bus.ped_req),     32'd1);
    check("lat_hold_walk", 32'(bus.walk_active), 32'd0);

    // Asynchronous reset while in REQUEST, mid-cycle.
    #3;
    reset = 1'b1;
    #1;
    check("arst_req",    32'(bus.ped_req),    32'd0);
    check("arst_lamp",   32'(bus.wait_lamp),  32'd0);
    check("arst_served", 32'(bus.served_cnt), 32'd0);
    tick(2);
    reset = 1'b0;

    // Bounce: toggle every cycle for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      bus.btn_raw = ~bus.btn_raw;
      tick(1);
    end
    bus.btn_raw = 1'b0;
    tick(8);
    check("bounce_req",  32'(bus.ped_req),   32'd0);
    check("bounce_lamp", 32'(bus.wait_lamp), 32'd0);

    // Full walk cycle.
    do_press("full");
    tick(4);
    bus.ped_green = 1'b1;
    tick(1);
    check("full_walk_req",  32'(bus.ped_req),     32'd0);
    check("full_walk_act",  32'(bus.walk_active), 32'd1);
    check("full_walk_lamp", 32'(bus.wait_lamp),   32'd0);
    tick(29);
    bus.ped_green = 1'b0;
    tick(1);
    check("full_cd_served", 32'(bus.served_cnt),  32'd1);
    check("full_cd_walk",   32'(bus.walk_active), 32'd0);
    check("full_cd_lamp",   32'(bus.wait_lamp),   32'd0);
    tick(20);
    check("full_idle_req",    32'(bus.ped_req),    32'd0);
    check("full_idle_served", 32'(bus.served_cnt), 32'd1);
    bus.ped_green = 1'b1;
    tick(3);
    check("idle_green_walk",   32'(bus.walk_active), 32'd0);
    check("idle_green_req",    32'(bus.ped_req),     32'd0);
    check("idle_green_served", 32'(bus.served_cnt),  32'd1);
    bus.ped_green = 1'b0;

    // Press during WALK is held as pending through cooldown.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    do_press("pend");
    bus.ped_green = 1'b1;
    tick(1);
    check("pend_walk", 32'(bus.walk_active), 32'd1);
    tick(10);
    bus.btn_raw = 1'b1;
    tick(7);
    check("pend_walk_lamp", 32'(bus.wait_lamp),   32'd0);
    check("pend_walk_act",  32'(bus.walk_active), 32'd1);
    bus.btn_raw = 1'b0;
    tick(3);
    bus.ped_green = 1'b0;
    tick(1);
    check("pend_cd_served", 32'(bus.served_cnt), 32'd1);
    check("pend_cd_lamp",   32'(bus.wait_lamp),  32'd1);
    check("pend_cd_req",    32'(bus.ped_req),    32'd0);
    tick(19);
    check("pend_cd_last_req",  32'(bus.ped_req),   32'd0);
    check("pend_cd_last_lamp", 32'(bus.wait_lamp), 32'd1);
    tick(1);
    check("pend_rereq",      32'(bus.ped_req),    32'd1);
    check("pend_rereq_lamp", 32'(bus.wait_lamp),  32'd1);
    check("pend_served",     32'(bus.served_cnt), 32'd1);

    // Request age timeout (flag only present with the optional feature).
    tick(15);
    check("to_before", 32'(bus.req_timeout), 32'd0);
    tick(1);
    check("to_hit", 32'(bus.req_timeout), 32'(exp_to));
    check("to_req", 32'(bus.ped_req),     32'd1);
    bus.ped_green = 1'b1;
    tick(2);
    bus.ped_green = 1'b0;
    tick(2);
    check("to_sticky", 32'(bus.req_timeout), 32'(exp_to));
    check("to_served", 32'(bus.served_cnt),  32'd2);
    check("to_req_lo", 32'(bus.ped_req),     32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
